// File: rtl/gb_apu_frame_seq.sv
// APU timing scheduler: free-running 16-bit DIV counter, 1/2 MHz clock enables and
// the 512 Hz frame sequencer that issues length, sweep and envelope strobes.
module gb_apu_frame_seq #(
   parameter int unsigned DIV_BIT = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       apu_on,
   input  logic       div_reset,
   output logic [7:0] div_o,
   output logic       tick_1m,
   output logic       tick_2m,
   output logic [2:0] fs_step,
   output logic       len_clk,
   output logic       sweep_clk,
   output logic       env_clk,
   output logic       len_skip_next
);

   logic [15:0] div;
   logic        div_prev;
   logic        fs_event;
   logic [2:0]  step_d;
   logic        len_d;
   logic        sweep_d;
   logic        env_d;

   assign div_o         = div[15:8];
   assign tick_2m       = div[0];
   assign tick_1m       = (div[1:0] == 2'b11);
   assign len_skip_next = fs_step[0];

   // A DIV clear while the tap bit is high still looks like a falling edge here.
   always_comb begin
      fs_event = div_prev & ~div[DIV_BIT] & apu_on;
      step_d   = fs_step;
      len_d    = 1'b0;
      sweep_d  = 1'b0;
      env_d    = 1'b0;
      if (!apu_on) begin
         step_d = '0;
      end else if (fs_event) begin
         len_d   = ~fs_step[0];
         sweep_d = (fs_step[1:0] == 2'b10);
         env_d   = (fs_step == 3'd7);
         step_d  = fs_step + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div       <= '0;
         div_prev  <= 1'b0;
         fs_step   <= '0;
         len_clk   <= 1'b0;
         sweep_clk <= 1'b0;
         env_clk   <= 1'b0;
      end else begin
         div       <= div_reset ? '0 : div + 16'd1;
         div_prev  <= div[DIV_BIT];
         fs_step   <= step_d;
         len_clk   <= len_d;
         sweep_clk <= sweep_d;
         env_clk   <= env_d;
      end
   end

endmodule

// File: tb/tb_gb_apu_frame_seq.sv
// Scoreboard bench for gb_apu_frame_seq: a 512 Hz instance and a fast-tap instance share
// stimulus; a frame-schedule model predicts every output, a monitor compares each cycle.
module tb_gb_apu_frame_seq;

   typedef logic [16:0] obs_t;
   typedef struct packed {
      obs_t a;
      obs_t b;
   } pair_t;

   logic clk = 1'b0;
   logic reset, apu_on, div_reset;

   logic [7:0] div_o_a, div_o_b;
   logic       t1_a, t2_a, len_a, sw_a, env_a, skip_a;
   logic       t1_b, t2_b, len_b, sw_b, env_b, skip_b;
   logic [2:0] step_a, step_b;
   obs_t       got_a, got_b;

   int n_cmp = 0;
   int n_bad = 0;
   bit started = 1'b0;
   pair_t sb[$];

   // model state: shared DIV value, per-instance tap history, step and strobes
   int unsigned m_cnt;
   int unsigned tap[2] = '{12, 8};
   bit          m_prev[2];
   int unsigned m_step[2];
   bit          m_len[2], m_sw[2], m_env[2];
   // frame schedule: L, -, L+S, -, L, -, L+S, E
   bit          LEN_TAB[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
   bit          SW_TAB[8]  = '{0, 0, 1, 0, 0, 0, 1, 0};
   bit          ENV_TAB[8] = '{0, 0, 0, 0, 0, 0, 0, 1};

   always #5 clk = ~clk;

   gb_apu_frame_seq #(.DIV_BIT(12)) dut_a (
      .clk(clk), .reset(reset), .apu_on(apu_on), .div_reset(div_reset),
      .div_o(div_o_a), .tick_1m(t1_a), .tick_2m(t2_a), .fs_step(step_a),
      .len_clk(len_a), .sweep_clk(sw_a), .env_clk(env_a), .len_skip_next(skip_a)
   );

   gb_apu_frame_seq #(.DIV_BIT(8)) dut_b (
      .clk(clk), .reset(reset), .apu_on(apu_on), .div_reset(div_reset),
      .div_o(div_o_b), .tick_1m(t1_b), .tick_2m(t2_b), .fs_step(step_b),
      .len_clk(len_b), .sweep_clk(sw_b), .env_clk(env_b), .len_skip_next(skip_b)
   );

   assign got_a = {div_o_a, t1_a, t2_a, step_a, len_a, sw_a, env_a, skip_a};
   assign got_b = {div_o_b, t1_b, t2_b, step_b, len_b, sw_b, env_b, skip_b};

   task automatic check(input string name, input obs_t got, input obs_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got div_o=%h t1=%b t2=%b step=%0d L=%b S=%b E=%b skip=%b required div_o=%h t1=%b t2=%b step=%0d L=%b S=%b E=%b skip=%b",
                  name, $time, got[16:9], got[8], got[7], got[6:4], got[3], got[2], got[1], got[0],
                  exp[16:9], exp[8], exp[7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s wait bound expired at t=%0t", name, $time);
   endtask

   function automatic obs_t model_obs(input int b);
      obs_t o;
      o = {8'(m_cnt >> 8), (m_cnt % 4) == 3, (m_cnt % 2) == 1, 3'(m_step[b]),
           m_len[b], m_sw[b], m_env[b], (m_step[b] % 2) == 1};
      return o;
   endfunction

   function automatic bit edge_pending(input int b);
      return m_prev[b] && (((m_cnt >> tap[b]) & 1) == 0);
   endfunction

   task automatic model_edge(input bit r, input bit on, input bit dr);
      bit now_bit, ev;
      if (r) begin
         m_cnt = 0;
         for (int b = 0; b < 2; b++) begin
            m_prev[b] = 0; m_step[b] = 0; m_len[b] = 0; m_sw[b] = 0; m_env[b] = 0;
         end
      end else begin
         for (int b = 0; b < 2; b++) begin
            now_bit  = ((m_cnt >> tap[b]) & 1) == 1;
            ev       = on && m_prev[b] && !now_bit;
            m_len[b] = ev && LEN_TAB[m_step[b]];
            m_sw[b]  = ev && SW_TAB[m_step[b]];
            m_env[b] = ev && ENV_TAB[m_step[b]];
            if (!on)     m_step[b] = 0;
            else if (ev) m_step[b] = (m_step[b] + 1) % 8;
            m_prev[b] = now_bit;
         end
         m_cnt = dr ? 0 : (m_cnt + 1) % 65536;
      end
   endtask

   // drive one cycle's inputs at the falling edge and queue the post-edge expectation
   task automatic cycle(input bit r, input bit on, input bit dr, input bit chk_async);
      pair_t p;
      @(negedge clk);
      reset = r; apu_on = on; div_reset = dr;
      if (chk_async) begin
         #1;
         check("async_reset_a", got_a, '0);
         check("async_reset_b", got_b, '0);
      end
      model_edge(r, on, dr);
      p.a = model_obs(0);
      p.b = model_obs(1);
      sb.push_back(p);
      started = 1'b1;
   endtask

   task automatic wait_cnt(input int unsigned target);
      int unsigned n = 0;
      while (m_cnt != target && n < 70000) begin
         cycle(0, 1, 0, 0);
         n++;
      end
      if (m_cnt != target) timeout("wait_cnt");
   endtask

   task automatic wait_step_b(input int unsigned s);
      int unsigned n = 0;
      while (m_step[1] != s && n < 5000) begin
         cycle(0, 1, 0, 0);
         n++;
      end
      if (m_step[1] != s) timeout("wait_step");
   endtask

   initial begin
      forever begin
         pair_t p;
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            p = sb.pop_front();
            check("dut12", got_a, p.a);
            check("dut8", got_b, p.b);
         end else if (started) begin
            timeout("scoreboard_empty");
         end
      end
   end

   initial begin
      bit on;
      int unsigned n;
      reset = 1'b1; apu_on = 1'b0; div_reset = 1'b0;
      m_cnt = 0;
      for (int b = 0; b < 2; b++) begin
         m_prev[b] = 0; m_step[b] = 0; m_len[b] = 0; m_sw[b] = 0; m_env[b] = 0;
      end
      repeat (3) cycle(1, 0, 0, 0);

      // first frame step after reset, then a long run of steps
      repeat (9000) cycle(0, 1, 0, 0);

      // DIV write with the tap bit high, then with it low
      cycle(0, 1, 1, 0);
      wait_cnt(16'h1800);
      cycle(0, 1, 1, 0);
      repeat (4) cycle(0, 1, 0, 0);
      wait_cnt(16'h0800);
      cycle(0, 1, 1, 0);
      repeat (8400) cycle(0, 1, 0, 0);

      // power off at step 5 across three tap edges, then back on
      wait_step_b(5);
      repeat (3 * 256 + 40) cycle(0, 0, 0, 0);
      repeat (600) cycle(0, 1, 0, 0);

      // power drops on the very cycle a step would execute
      n = 0;
      while (!edge_pending(1) && n < 600) begin
         cycle(0, 1, 0, 0);
         n++;
      end
      if (!edge_pending(1)) timeout("wait_edge");
      cycle(0, 0, 0, 0);
      repeat (300) cycle(0, 1, 0, 0);

      // random power toggles and DIV writes
      on = 1'b1;
      repeat (6000) begin
         if ($urandom_range(399, 0) == 0) on = ~on;
         cycle(0, on, $urandom_range(299, 0) == 0, 0);
      end

      // asynchronous reset mid-sequence, then the full first-step latency again
      wait_step_b(3);
      cycle(1, 1, 0, 1);
      cycle(1, 1, 0, 0);
      repeat (8300) cycle(0, 1, 0, 0);

      @(posedge clk);
      #2;
      if (sb.size() != 0) timeout("scoreboard_leftover");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gb_apu_frame_seq.md
Name: gb_apu_frame_seq

Overview:
- Timing scheduler for the APU: an internal 16-bit DIV counter at the 4194304 Hz system clock.
- Decodes the 512 Hz frame-sequencer steps into one-cycle length, envelope and sweep strobes for the channel blocks inside gb_apu.
- Also supplies 1 MHz and 2 MHz clock enables and the DIV read value.
- Sits between the register file (power, DIV writes) and the four channel datapaths.

Parameters:
- DIV_BIT, 12, DIV counter bit whose falling edge advances the frame sequencer (12 = 512 Hz at 4.194304 MHz; 13 for double-speed builds).

Ports:
- clk  input  1  system clock, 4194304 Hz
- reset  input  1  asynchronous, active-high reset
- apu_on  input  1  NR52 bit 7 (APU master power)
- div_reset  input  1  one-cycle pulse: CPU write to FF04 clears the DIV counter
- div_o  output  8  DIV counter bits [15:8], returned on FF04 reads
- tick_1m  output  1  clock enable, high 1 cycle in 4
- tick_2m  output  1  clock enable, high 1 cycle in 2
- fs_step  output  3  index of the next frame step to execute
- len_clk  output  1  one-cycle length-counter strobe
- sweep_clk  output  1  one-cycle ch1 sweep strobe
- env_clk  output  1  one-cycle envelope strobe
- len_skip_next  output  1  high when the next step will not clock length (extra-length-clock quirk input for channels)

Behaviour:
- Reset (async) values:
  - div = 0, div_prev = 0, fs_step = 0.
  - All strobes 0, tick_1m = 0, tick_2m = 0, div_o = 0, len_skip_next = 0.
- DIV counter:
  - 16-bit, increments every clk and wraps 0xFFFF -> 0x0000.
  - Runs regardless of apu_on.
  - div_reset loads 0 on that edge; div_reset takes priority over increment.
- div_o = div[15:8], combinational from the register.
- Clock enables:
  - tick_2m = div[0]; tick_1m = (div[1:0] == 2'b11).
  - Decoded from the registered counter, so both are 0 out of reset.
- Falling-edge detection:
  - div_prev registers div[DIV_BIT] every cycle.
  - fs_event = div_prev & ~div[DIV_BIT] & apu_on.
  - A div_reset while div[DIV_BIT] = 1 therefore produces a valid event one cycle later (hardware-accurate quirk).
- Step decode, on the edge following fs_event:
  - len_clk <= fs_step in {0,2,4,6}
  - sweep_clk <= fs_step in {2,6}
  - env_clk <= fs_step == 7
  - fs_step <= fs_step + 1, wrapping 7 -> 0.
  - Strobes are registered and high for exactly one cycle.
- len_skip_next = fs_step[0], combinational.
- Latency: the first falling edge of div[12] after reset occurs at div = 8192. The strobe is high during the cycle after the 8193rd rising edge following reset deassertion. The period thereafter is 8192 cycles.
- Power control:
  - While apu_on = 0: fs_step is forced to 0 each cycle, no strobes fire, and DIV and the ticks keep running.
  - On apu_on rising, the next fs_event executes step 0.
  - If apu_on falls in the same cycle as fs_event, no strobe fires and fs_step becomes 0.
- No state other than div, div_prev, fs_step and the three strobe registers.

Test Plan:
- Reset, apu_on = 1, run 8193 cycles -> len_clk high exactly at cycle 8193, fs_step 0 -> 1, sweep_clk and env_clk low.
- Run 8 x 8192 cycles -> strobe sequence L, -, L+S, -, L, -, L+S, E; fs_step wraps 7 -> 0; each strobe is exactly 1 cycle wide.
- Check clock enables over 16 cycles after reset: tick_2m pattern 0101..., tick_1m high when div[1:0] = 3 (every 4th cycle). Check div_o = 0x20 at div = 0x2000.
- div_reset at div = 0x1800 (bit12 = 1) -> step strobe one cycle later, then next step 8192 cycles after the reset. div_reset at div = 0x0800 -> no strobe.
- Power sequencing:
  - Clear apu_on at fs_step = 5 -> fs_step reads 0, no strobes across 3 bit-12 falling edges.
  - Set apu_on -> the next edge gives len_clk (step 0) and len_skip_next = 1 afterward.
- Assert reset mid-sequence (fs_step = 3, div = 0x5000) -> all outputs 0 immediately, without waiting for clk. After release, first strobe after 8193 cycles.
